// File: rtl/decode_pkg.sv
// Shared types and helpers for the decode_scan block: the controller state
// encoding and the output-count helper derived from the select width.
package decode_pkg;

    // Controller states. IDLE drives no output active, HOLD keeps one static
    // index selected, SCAN steps the index with a programmable dwell.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_e;

    // Number of decoded outputs for a given select width.
    function automatic int num_outputs(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/decode_onehot.sv
// Combinational index-to-one-hot decoder with output polarity selection.
// When 'active' is low no output is asserted, which gives the IDLE pattern
// (all 0 for active-high, all 1 for active-low) from the same logic.
module decode_onehot
    import decode_pkg::*;
#(
    parameter int SEL_W       = 2,
    parameter int ACTIVE_HIGH = 1
) (
    input  logic [SEL_W-1:0]      idx,
    input  logic                  active,
    output logic [(2**SEL_W)-1:0] vec
);

    localparam int N = num_outputs(SEL_W);

    logic [N-1:0] onehot;

    // Build the active-high one-hot pattern, then apply the output polarity.
    always_comb begin
        onehot = '0;
        if (active) begin
            onehot[idx] = 1'b1;
        end
        vec = (ACTIVE_HIGH != 0) ? onehot : ~onehot;
    end

endmodule

// File: rtl/decode_scan.sv
// Registered decoder / scanner.
// A load strobe selects either a static index (HOLD) or a scan that walks the
// index upward, holding each value for dwell+1 enabled cycles (SCAN). clr
// returns to IDLE with every output inactive. All outputs come from flops.
//
// Command semantics: there is no ready; load is a single-cycle strobe that
// is taken on any rising edge where en=1, and its effect is visible on d/idx
// right after that same edge. clr wins over load in the same cycle, and en=0
// ignores both.
module decode_scan
    import decode_pkg::*;
#(
    parameter int SEL_W       = 2,
    parameter int DWELL_W     = 4,
    parameter int ACTIVE_HIGH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] d,
    output logic [SEL_W-1:0]      idx,
    output logic                  busy,
    output logic                  wrap,
    output state_e                state_dbg
);

    localparam int           N      = num_outputs(SEL_W);
    localparam logic [N-1:0] D_IDLE = (ACTIVE_HIGH != 0) ? '0 : '1;

    state_e               state_q;
    state_e               state_d;
    logic [DWELL_W-1:0]   cnt_q;
    logic [DWELL_W-1:0]   cnt_d;
    logic [DWELL_W-1:0]   rld_q;
    logic [DWELL_W-1:0]   rld_d;
    logic [SEL_W-1:0]     idx_d;
    logic                 wrap_d;
    logic                 busy_d;
    logic [N-1:0]         d_d;

    assign state_dbg = state_q;

    // State register: frozen while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clr beats load, load goes to HOLD or SCAN from anywhere.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else if (load) begin
            state_d = mode ? SCAN : HOLD;
        end
    end

    // Datapath next values: index, dwell counter, reload register and wrap.
    // idx is kept on clr so IDLE still reports the last selected index.
    always_comb begin
        idx_d  = idx;
        cnt_d  = cnt_q;
        rld_d  = rld_q;
        wrap_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            idx_d = sel;
            if (mode) begin
                rld_d = dwell;
                cnt_d = '0;
            end
        end else if (state_q == SCAN) begin
            if (cnt_q == rld_q) begin
                cnt_d  = '0;
                idx_d  = idx + SEL_W'(1);
                // All-ones index is N-1, so this step rolls over to 0.
                wrap_d = &idx;
            end else begin
                cnt_d = cnt_q + DWELL_W'(1);
            end
        end
    end

    assign busy_d = (state_d == SCAN);

    // Decode the next index so d lands in the same cycle as idx.
    decode_onehot #(
        .SEL_W       (SEL_W),
        .ACTIVE_HIGH (ACTIVE_HIGH)
    ) u_onehot (
        .idx    (idx_d),
        .active (state_d != IDLE),
        .vec    (d_d)
    );

    // Output and counter registers; wrap is a pulse so it drops while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            cnt_q <= '0;
            rld_q <= '0;
            busy  <= 1'b0;
            wrap  <= 1'b0;
            d     <= D_IDLE;
        end else if (en) begin
            idx   <= idx_d;
            cnt_q <= cnt_d;
            rld_q <= rld_d;
            busy  <= busy_d;
            wrap  <= wrap_d;
            d     <= d_d;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_scan.sv
// Randomised scoreboard bench for decode_scan. Two instances (active-high and
// active-low) share the same stimulus. The driver steps a reference model
// that describes a scan by its start index, dwell and elapsed enabled cycles,
// and queues the expected registered outputs; a monitor pops and compares
// after every rising edge.
module tb_decode_scan;
    import decode_pkg::*;

    localparam int SEL_W   = 2;
    localparam int DWELL_W = 4;
    localparam int N       = 4;
    localparam int W       = N + SEL_W + 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               clr = 1'b0;
    logic               load = 1'b0;
    logic               mode = 1'b0;
    logic [SEL_W-1:0]   sel = '0;
    logic [DWELL_W-1:0] dwell = '0;

    logic [N-1:0]       d_h, d_l;
    logic [SEL_W-1:0]   idx_h, idx_l;
    logic               busy_h, busy_l, wrap_h, wrap_l;
    state_e             st_h, st_l;

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: 0 idle, 1 hold, 2 scan.
    int m_state, m_idx, m_start, m_rld, m_k;
    bit m_wrap;

    decode_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .ACTIVE_HIGH(1)) dut_h (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .mode(mode),
        .sel(sel), .dwell(dwell), .d(d_h), .idx(idx_h), .busy(busy_h),
        .wrap(wrap_h), .state_dbg(st_h)
    );

    decode_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .ACTIVE_HIGH(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .mode(mode),
        .sel(sel), .dwell(dwell), .d(d_l), .idx(idx_l), .busy(busy_l),
        .wrap(wrap_l), .state_dbg(st_l)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (d|idx|busy|wrap) at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_state = 0; m_idx = 0; m_start = 0; m_rld = 0; m_k = 0; m_wrap = 1'b0;
    endfunction

    // One enabled/disabled clock of the reference behaviour.
    function automatic void model_step(input bit e, input bit c, input bit l, input bit m,
                                       input int s, input int dw);
        m_wrap = 1'b0;
        if (!e) return;
        if (c) begin
            m_state = 0;
        end else if (l) begin
            m_idx = s;
            if (m) begin
                m_state = 2; m_start = s; m_rld = dw; m_k = 0;
            end else begin
                m_state = 1;
            end
        end else if (m_state == 2) begin
            m_k++;
            m_idx  = (m_start + m_k / (m_rld + 1)) % N;
            m_wrap = ((m_k % (m_rld + 1)) == 0) && (m_idx == 0);
        end
    endfunction

    function automatic logic [W-1:0] exp_pack();
        logic [N-1:0] dv;
        dv = '0;
        if (m_state != 0) dv[m_idx] = 1'b1;
        return {dv, SEL_W'(m_idx), (m_state == 2), m_wrap};
    endfunction

    // Driver: apply one cycle of inputs at the falling edge and queue the result.
    task automatic drive_cycle(input bit e, input bit c, input bit l, input bit m,
                               input int s, input int dw);
        @(negedge clk);
        en = e; clr = c; load = l; mode = m;
        sel = SEL_W'(s); dwell = DWELL_W'(dw);
        model_step(e, c, l, m, s, dw);
        exp_q.push_back(exp_pack());
    endtask

    // Monitor / scoreboard: one expected entry per driven cycle.
    initial begin : monitor
        logic [W-1:0] e_h, e_l;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e_h = exp_q.pop_front();
                e_l = {~e_h[W-1 -: N], e_h[SEL_W+1:0]};
                check("out_active_high", {d_h, idx_h, busy_h, wrap_h}, e_h);
                check("out_active_low",  {d_l, idx_l, busy_l, wrap_l}, e_l);
            end
        end
    end

    // Stimulus
    initial begin
        int dw;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("reset_h", {d_h, idx_h, busy_h, wrap_h}, {4'b0000, 2'd0, 1'b0, 1'b0});
        check("reset_l", {d_l, idx_l, busy_l, wrap_l}, {4'b1111, 2'd0, 1'b0, 1'b0});
        n_tests++;
        if (st_h !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required %0d", st_h, IDLE);
        end
        rst_n = 1'b1;

        // Static load sel=2, then consecutive static loads 0..3
        drive_cycle(1, 0, 1, 0, 2, 0);
        for (int i = 0; i < N; i++) drive_cycle(1, 0, 1, 0, i, 0);
        drive_cycle(1, 0, 0, 0, 0, 0);

        // Scan from 3 with dwell 1 across a wrap
        drive_cycle(1, 0, 1, 1, 3, 1);
        repeat (10) drive_cycle(1, 0, 0, 0, 0, 0);

        // Zero dwell with a 3-cycle freeze (a load during freeze is ignored)
        drive_cycle(1, 0, 1, 1, 0, 0);
        repeat (2) drive_cycle(1, 0, 0, 0, 0, 0);
        repeat (3) drive_cycle(0, 0, 1, 0, 2, 0);
        repeat (4) drive_cycle(1, 0, 0, 0, 0, 0);

        // Restart mid-scan, then clr together with load
        drive_cycle(1, 0, 1, 1, 2, 3);
        repeat (3) drive_cycle(1, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 1, 1, 3, 0);
        drive_cycle(1, 0, 0, 0, 0, 0);
        drive_cycle(1, 1, 1, 0, 3, 0);
        repeat (2) drive_cycle(1, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-dwell
        drive_cycle(1, 0, 1, 1, 1, 5);
        repeat (3) drive_cycle(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_h", {d_h, idx_h, busy_h, wrap_h}, {4'b0000, 2'd0, 1'b0, 1'b0});
        check("async_rst_l", {d_l, idx_l, busy_l, wrap_l}, {4'b1111, 2'd0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        check("rst_hold_h", {d_h, idx_h, busy_h, wrap_h}, {4'b0000, 2'd0, 1'b0, 1'b0});
        model_reset();
        #2;
        rst_n = 1'b1;
        // First load after reset release is taken on the first edge
        drive_cycle(1, 0, 1, 1, 2, 0);
        repeat (3) drive_cycle(1, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            dw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            drive_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                        $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, N - 1), dw);
        end

        @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_scan.md
DECODE_SCAN -- requirements
Module: decode_scan

Interface
REQ-001 Parameter SEL_W, default 2: select width; output count N = 2**SEL_W.
REQ-002 Parameter DWELL_W, default 4: width of the per-step dwell count.
REQ-003 Parameter ACTIVE_HIGH, default 1: 1 = selected output driven 1; 0 = selected output driven 0, all others 1.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  clock enable; when low, all state and outputs freeze.
REQ-008 clr  in  1  synchronous clear to IDLE.
REQ-009 load  in  1  command strobe; sampled only when en=1.
REQ-010 mode  in  1  command type, qualified by load: 0 = static decode, 1 = scan.
REQ-011 sel  in  SEL_W  decode index for static mode; start index for scan.
REQ-012 dwell  in  DWELL_W  scan step hold; each index is held for dwell+1 cycles, latched on load.
REQ-013 d  out  N  registered decoded outputs.
REQ-014 idx  out  SEL_W  registered currently selected index.
REQ-015 busy  out  1  high while in SCAN.
REQ-016 wrap  out  1  one-cycle pulse when a scan wraps from N-1 to 0.

Function
REQ-017 The block has exactly three states: IDLE, HOLD and SCAN.
REQ-018 IDLE: d is all inactive (0 when ACTIVE_HIGH=1, all 1 when ACTIVE_HIGH=0); idx holds its last value.
REQ-019 Static load (en=1, load=1, mode=0) moves the block to HOLD from any state, and on the next edge sets idx=sel and d=onehot(sel), inverted when ACTIVE_HIGH=0.
REQ-020 Scan load (en=1, load=1, mode=1) moves the block to SCAN from any state, sets idx=sel, latches dwell into an internal reload register and clears the dwell counter; d reflects the new idx one cycle after load.
REQ-021 In SCAN, the dwell counter increments each enabled cycle; when it equals the latched dwell, it clears and idx advances by 1.
REQ-022 Index wrap: when idx advances from N-1 to 0, wrap pulses high for exactly that one cycle, coincident with idx=0.
REQ-023 Zero dwell: dwell=0 advances idx on every enabled cycle.
REQ-024 Load during SCAN restarts the scan with the new sel and dwell, discarding the in-progress dwell count; wrap is not asserted by a restart.
REQ-025 clr=1 with en=1 moves the block to IDLE on the next edge with busy=0, wrap=0 and d all inactive.
REQ-026 clr has priority over load when both are asserted in the same cycle.
REQ-027 en=0 freezes state, idx, d, the dwell counter and busy; wrap is forced to 0 while en=0.
REQ-028 Exactly one bit of d is active in HOLD and SCAN; no bit of d is active in IDLE.
REQ-029 d, idx, busy and wrap are driven from flops only, with no combinational input-to-output path.
REQ-030 The latency from a sampled load to the updated d and idx is exactly 1 cycle.

Reset
REQ-031 rst_n low asynchronously forces: state=IDLE, idx=0, dwell counter and reload register=0, busy=0, wrap=0, d all inactive per ACTIVE_HIGH.
REQ-032 Reset asserted mid-scan aborts the scan immediately, with no wrap pulse.
REQ-033 After rst_n deasserts, the first load is honoured on the first rising edge.

Structure
REQ-034 Shared package decode_pkg holds the state enum (IDLE, HOLD, SCAN) and the helper constant for N.
REQ-035 The combinational index-to-one-hot conversion, including the polarity inversion, is a sub-module decode_onehot, parameterised by SEL_W and ACTIVE_HIGH.
REQ-036 decode_scan contains only the state machine, counters and output registers.

Verification
REQ-037 Reset, then SEL_W=2, ACTIVE_HIGH=1, static load sel=2 -> next cycle d=4'b0100, idx=2, busy=0.
REQ-038 ACTIVE_HIGH=0, static loads sel=0,1,2,3 on consecutive cycles -> d=1110, 1101, 1011, 0111, each one cycle after its load.
REQ-039 Scan load sel=3, dwell=1 -> idx sequence 3,3,0,0,1,1,...; wrap=1 only on the first cycle of idx=0; busy=1 throughout.
REQ-040 Scan with dwell=0, en=0 held for 3 cycles mid-scan -> idx and d frozen, wrap=0; on en=1 the count resumes from the frozen index.
REQ-041 clr and load asserted in the same cycle during SCAN -> IDLE with d=0000, busy=0; the load is ignored.
REQ-042 rst_n asserted asynchronously mid-dwell during SCAN -> d=0000, idx=0, busy=0 before the next clock edge; no wrap pulse.
